fifo_ptr_ctrl: RTL

Pointer, occupancy and flag controller for the synchronous FIFO. It owns the binary write/read pointers and the occupancy count, and arbitrates the single RAM write port between two write requesters with round-robin priority. It gates accesses against full and empty, and produces registered status flags and sticky error flags. It sits between the requesters, the reader and the dual-port FIFO RAM, and replaces any combinational pointer-difference logic with a registered count.

---
 rtl/fifo_ptr_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: pointer, occupancy and status controller for a synchronous FIFO.
// Owns the binary write/read pointers and a registered occupancy count, and
// arbitrates the single RAM write port between two requesters with
// round-robin priority. Accesses are gated against full and empty. The status
// flags are derived from the next count and registered, so they always agree
// with the count seen in the same cycle. Overflow/underflow are sticky until
// cleared.
module fifo_ptr_ctrl #(
  parameter int A_LENGTH  = 3,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wr_req0,
  input  logic                wr_req1,
  input  logic                rd_req,
  input  logic                err_clr,
  output logic                wr_gnt0,
  output logic                wr_gnt1,
  output logic                wr_en,
  output logic                rd_en,
  output logic [A_LENGTH-1:0] wr_addr,
  output logic [A_LENGTH-1:0] rd_addr,
  output logic [A_LENGTH:0]   count,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic                overflow,
  output logic                underflow
);

  // Count-width constants. The count is one bit wider than the address so
  // that it can represent DEPTH itself.
  localparam logic [A_LENGTH:0] ONE       = {{A_LENGTH{1'b0}}, 1'b1};
  localparam logic [A_LENGTH:0] ZERO      = '0;
  localparam logic [A_LENGTH:0] DEPTH_CNT = {1'b1, {A_LENGTH{1'b0}}};
  localparam logic [A_LENGTH:0] AF_LVL    = AF_THRESH[A_LENGTH:0];
  localparam logic [A_LENGTH:0] AE_LVL    = AE_THRESH[A_LENGTH:0];

  // Pointers carry a wrap MSB above the RAM address bits.
  logic [A_LENGTH:0] wr_ptr;
  logic [A_LENGTH:0] rd_ptr;
  logic [A_LENGTH:0] count_next;
  // Requester granted most recently; 1 at reset so requester 0 wins first.
  logic              last_gnt;
  logic              gnt0_c;
  logic              gnt1_c;

  // Occupancy step: +1 on a lone write, -1 on a lone read, otherwise held.
  function automatic logic [A_LENGTH:0] step_count(
    input logic [A_LENGTH:0] cur,
    input logic              wr,
    input logic              rd
  );
    logic [A_LENGTH:0] nxt;
    case ({wr, rd})
      2'b10:   nxt = cur + ONE;
      2'b01:   nxt = cur - ONE;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  // Sticky error update: a new event in the same cycle as a clear wins.
  function automatic logic sticky_next(
    input logic cur,
    input logic event_hit,
    input logic clr
  );
    return event_hit | (cur & ~clr);
  endfunction

  // Write arbitration from registered full; alternate on contention and
  // suppress all grants while reset is held.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (reset_n && !full) begin
      if (wr_req0 && wr_req1) begin
        if (last_gnt) begin
          gnt0_c = 1'b1;
        end else begin
          gnt1_c = 1'b1;
        end
      end else begin
        gnt0_c = wr_req0;
        gnt1_c = wr_req1;
      end
    end
  end

  assign wr_gnt0 = gnt0_c;
  assign wr_gnt1 = gnt1_c;
  assign wr_en   = gnt0_c | gnt1_c;
  assign rd_en   = reset_n & rd_req & ~empty;
  assign wr_addr = wr_ptr[A_LENGTH-1:0];
  assign rd_addr = rd_ptr[A_LENGTH-1:0];

  // Next occupancy from the accepted strobes of this cycle.
  always_comb begin
    count_next = step_count(count, wr_en, rd_en);
  end

  // Pointer advance on accepted accesses; wraps modulo 2**(A_LENGTH+1).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= ZERO;
      rd_ptr <= ZERO;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + ONE;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + ONE;
      end
    end
  end

  // Round-robin history: only a real grant moves it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_gnt <= 1'b1;
    end else if (gnt0_c) begin
      last_gnt <= 1'b0;
    end else if (gnt1_c) begin
      last_gnt <= 1'b1;
    end
  end

  // Registered count and status flags, all derived from count_next.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count        <= ZERO;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      count        <= count_next;
      full         <= (count_next == DEPTH_CNT);
      empty        <= (count_next == ZERO);
      almost_full  <= (count_next >= AF_LVL);
      almost_empty <= (count_next <= AE_LVL);
    end
  end

  // Sticky error flags: any write request while full, any read while empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= sticky_next(overflow, (wr_req0 | wr_req1) & full, err_clr);
      underflow <= sticky_next(underflow, rd_req & empty, err_clr);
    end
  end

endmodule
